// File: rtl/keycode_cmd_ctrl.sv
// Frame-synchronous HID keycode to player-command controller: latches
// left/right/run state per frame and runs a one-jump-per-press request handshake.
module keycode_cmd_ctrl #(
    parameter logic [7:0]  KEY_LEFT     = 8'h04,
    parameter logic [7:0]  KEY_RIGHT    = 8'h07,
    parameter logic [7:0]  KEY_JUMP     = 8'h1A,
    parameter logic [7:0]  KEY_JUMP_ALT = 8'h2C,
    parameter int unsigned RUN_FRAMES   = 30,
    parameter int unsigned JUMP_TIMEOUT = 8
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic [7:0] keycode,
    input  logic       frame_tick,
    input  logic       jump_ack,
    output logic       move_left,
    output logic       move_right,
    output logic       facing_left,
    output logic       run,
    output logic       jump_req
);
    localparam int RW = $clog2(RUN_FRAMES + 1);
    localparam int TW = $clog2(JUMP_TIMEOUT + 1);
    localparam logic [RW-1:0] RUN_MAX  = RW'(RUN_FRAMES);
    localparam logic [TW-1:0] TMO_LAST = TW'(JUMP_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, PEND, WAIT_REL} jump_state_t;

    logic [7:0]    r_kc_q;
    logic          w_is_left;
    logic          w_is_right;
    logic          w_jump_hit;
    logic          w_same_dir;
    logic [RW-1:0] r_run_cnt;
    logic [RW-1:0] w_run_cnt_nxt;
    logic          r_move_left;
    logic          r_move_right;
    logic          r_facing_left;
    logic          r_run;
    logic          r_jump_req;
    jump_state_t   r_state;
    logic [TW-1:0] r_tmo;

    assign w_is_left  = (r_kc_q == KEY_LEFT);
    assign w_is_right = (r_kc_q == KEY_RIGHT);
    assign w_jump_hit = (r_kc_q == KEY_JUMP) || (r_kc_q == KEY_JUMP_ALT);
    assign w_same_dir = (w_is_left && r_move_left) || (w_is_right && r_move_right);

    always_comb begin
        // NOTE: default first so every path assigns the signal and no latch is inferred.
        w_run_cnt_nxt = '0;
        if (w_same_dir) begin
            w_run_cnt_nxt = (r_run_cnt == RUN_MAX) ? RUN_MAX : r_run_cnt + RW'(1);
        end else if (w_is_left || w_is_right) begin
            w_run_cnt_nxt = RW'(1);
        end
    end

    // NOTE: reset is sampled on the clock edge, so it also overrides a same-cycle frame_tick.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_kc_q        <= '0;
            r_move_left   <= 1'b0;
            r_move_right  <= 1'b0;
            r_facing_left <= 1'b0;
            r_run_cnt     <= '0;
            r_run         <= 1'b0;
        end else begin
            r_kc_q <= keycode;
            if (frame_tick) begin
                r_move_left  <= w_is_left;
                r_move_right <= w_is_right;
                if (w_is_left) begin
                    r_facing_left <= 1'b1;
                end else if (w_is_right) begin
                    r_facing_left <= 1'b0;
                end
                r_run_cnt <= w_run_cnt_nxt;
                r_run     <= (w_run_cnt_nxt == RUN_MAX);
            end
        end
    end

    // Ack beats a coinciding frame_tick; WAIT_REL needs a key-free tick so a held key fires once.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_state    <= IDLE;
            r_jump_req <= 1'b0;
            r_tmo      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (frame_tick && w_jump_hit) begin
                        r_state    <= PEND;
                        r_jump_req <= 1'b1;
                        r_tmo      <= '0;
                    end
                end
                PEND: begin
                    if (jump_ack) begin
                        r_state    <= WAIT_REL;
                        r_jump_req <= 1'b0;
                    end else if (frame_tick) begin
                        if (r_tmo == TMO_LAST) begin
                            r_state    <= WAIT_REL;
                            r_jump_req <= 1'b0;
                        end else begin
                            r_tmo <= r_tmo + TW'(1);
                        end
                    end
                end
                WAIT_REL: begin
                    if (frame_tick && !w_jump_hit) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_jump_req <= 1'b0;
                end
            endcase
        end
    end

    assign move_left   = r_move_left;
    assign move_right  = r_move_right;
    assign facing_left = r_facing_left;
    assign run         = r_run;
    assign jump_req    = r_jump_req;

endmodule
